// File: rtl/controller_pkg.sv
// rtl/controller_pkg.sv - shared types and encodings for the multicycle controller
//
// Purpose : state enum, opcode constants, datapath select encodings and the
//           immediate-format helper used by multicycle_controller and alu_decoder.
// Ports   : none (package).
package controller_pkg;

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMREAD  = 4'd3,
      MEMWB    = 4'd4,
      MEMWRITE = 4'd5,
      EXECUTER = 4'd6,
      EXECUTEI = 4'd7,
      ALUWB    = 4'd8,
      JAL      = 4'd9,
      BEQ      = 4'd10,
      LUI      = 4'd11
   } state_t;

   typedef logic [1:0] aluop_t;

   localparam aluop_t ALUOP_ADD   = 2'b00;
   localparam aluop_t ALUOP_SUB   = 2'b01;
   localparam aluop_t ALUOP_FUNCT = 2'b10;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_JAL = 7'b1101111;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_LUI = 7'b0110111;

   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;
   localparam logic [1:0] RES_IMMEXT    = 2'b11;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_A     = 2'b10;

   localparam logic [1:0] SRCB_WD   = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   localparam logic [2:0] IMM_I = 3'b000;
   localparam logic [2:0] IMM_S = 3'b001;
   localparam logic [2:0] IMM_B = 3'b010;
   localparam logic [2:0] IMM_J = 3'b011;
   localparam logic [2:0] IMM_U = 3'b100;

   // Immediate format depends only on the opcode; unknown opcodes fall back to I.
   function automatic logic [2:0] imm_src_of(input logic [6:0] op);
      case (op)
         OP_SW:   imm_src_of = IMM_S;
         OP_BEQ:  imm_src_of = IMM_B;
         OP_JAL:  imm_src_of = IMM_J;
         OP_LUI:  imm_src_of = IMM_U;
         default: imm_src_of = IMM_I;
      endcase
   endfunction

endpackage

// File: rtl/alu_decoder.sv
// rtl/alu_decoder.sv - maps ALUOp/funct fields to the ALU operation code
//
// Purpose : second-level ALU decode for the multicycle controller.
// Ports   : ALUOp (2, in), funct3 (3, in), op5 (1, in, opcode bit 5),
//           funct7b5 (1, in), ALUControl (3, out).
module alu_decoder
   import controller_pkg::*;
(
   input  aluop_t     ALUOp,
   input  logic [2:0] funct3,
   input  logic       op5,
   input  logic       funct7b5,
   output logic [2:0] ALUControl
);

   always_comb begin
      ALUControl = ALU_ADD;
      case (ALUOp)
         ALUOP_SUB: ALUControl = ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct3)
               // sub only for register-register ops; addi never subtracts
               3'b000:  ALUControl = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
               3'b010:  ALUControl = ALU_SLT;
               3'b110:  ALUControl = ALU_OR;
               3'b111:  ALUControl = ALU_AND;
               default: ALUControl = ALU_ADD;
            endcase
         end
         default: ALUControl = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - main FSM of the multicycle RISC-V datapath
//
// Purpose : sequences fetch/decode/execute/memory/writeback and drives every
//           datapath select and write enable.
// Config  : MEM_HANDSHAKE_EN - when defined, FETCH/MEMREAD/MEMWRITE wait for
//           MemReady; otherwise MemReady is ignored.
// Ports   : clk, reset_n (async, active low); op[6:0], funct3[2:0], funct7b5,
//           Zero, MemReady in; PCWrite, AdrSrc, MemWrite, MemReq, IRWrite,
//           RegWrite, ResultSrc[1:0], ALUSrcA[1:0], ALUSrcB[1:0],
//           ALUControl[2:0], ImmSrc[2:0] out.
module multicycle_controller
   import controller_pkg::*;
(
   input  logic       clk,
   input  logic       reset_n,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       Zero,
   input  logic       MemReady,
   output logic       PCWrite,
   output logic       AdrSrc,
   output logic       MemWrite,
   output logic       MemReq,
   output logic       IRWrite,
   output logic       RegWrite,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [2:0] ALUControl,
   output logic [2:0] ImmSrc
);

   state_t state_q, state_d;

   aluop_t alu_op;
   logic   pc_update, branch;
   logic   mem_write_raw, mem_req_raw, ir_write_raw, reg_write_raw;
   logic   mem_ready;

`ifdef MEM_HANDSHAKE_EN
   assign mem_ready = MemReady;
`else
   logic unused_mem_ready;
   assign unused_mem_ready = MemReady;
   assign mem_ready        = 1'b1;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= FETCH;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d       = state_q;
      AdrSrc        = 1'b0;
      mem_write_raw = 1'b0;
      mem_req_raw   = 1'b0;
      ir_write_raw  = 1'b0;
      reg_write_raw = 1'b0;
      ResultSrc     = RES_ALUOUT;
      ALUSrcA       = SRCA_PC;
      ALUSrcB       = SRCB_WD;
      alu_op        = ALUOP_ADD;
      pc_update     = 1'b0;
      branch        = 1'b0;
      case (state_q)
         FETCH: begin
            mem_req_raw  = 1'b1;
            ALUSrcB      = SRCB_FOUR;
            ResultSrc    = RES_ALURESULT;
            // IR and PC only advance once the instruction word is actually there
            ir_write_raw = mem_ready;
            pc_update    = mem_ready;
            if (mem_ready) state_d = DECODE;
         end
         DECODE: begin
            ALUSrcA = SRCA_OLDPC;
            ALUSrcB = SRCB_IMM;
            case (op)
               OP_LW, OP_SW: state_d = MEMADR;
               OP_R:         state_d = EXECUTER;
               OP_I:         state_d = EXECUTEI;
               OP_JAL:       state_d = JAL;
               OP_BEQ:       state_d = BEQ;
               OP_LUI:       state_d = LUI;
               default:      state_d = FETCH;
            endcase
         end
         MEMADR: begin
            ALUSrcA = SRCA_A;
            ALUSrcB = SRCB_IMM;
            state_d = (op == OP_LW) ? MEMREAD : MEMWRITE;
         end
         MEMREAD: begin
            AdrSrc      = 1'b1;
            mem_req_raw = 1'b1;
            if (mem_ready) state_d = MEMWB;
         end
         MEMWB: begin
            ResultSrc     = RES_DATA;
            reg_write_raw = 1'b1;
            state_d       = FETCH;
         end
         MEMWRITE: begin
            AdrSrc        = 1'b1;
            mem_req_raw   = 1'b1;
            mem_write_raw = 1'b1;
            if (mem_ready) state_d = FETCH;
         end
         EXECUTER: begin
            ALUSrcA = SRCA_A;
            ALUSrcB = SRCB_WD;
            alu_op  = ALUOP_FUNCT;
            state_d = ALUWB;
         end
         EXECUTEI: begin
            ALUSrcA = SRCA_A;
            ALUSrcB = SRCB_IMM;
            alu_op  = ALUOP_FUNCT;
            state_d = ALUWB;
         end
         ALUWB: begin
            reg_write_raw = 1'b1;
            state_d       = FETCH;
         end
         JAL: begin
            ALUSrcA   = SRCA_OLDPC;
            ALUSrcB   = SRCB_FOUR;
            pc_update = 1'b1;
            state_d   = ALUWB;
         end
         BEQ: begin
            ALUSrcA = SRCA_A;
            ALUSrcB = SRCB_WD;
            alu_op  = ALUOP_SUB;
            branch  = 1'b1;
            state_d = FETCH;
         end
         LUI: begin
            ResultSrc     = RES_IMMEXT;
            reg_write_raw = 1'b1;
            state_d       = FETCH;
         end
         default: state_d = FETCH;
      endcase
   end

   // Enables are masked by reset directly so nothing writes while reset is low;
   // the selects already show FETCH values because state_q is forced to FETCH.
   assign PCWrite  = reset_n & (pc_update | (branch & Zero));
   assign IRWrite  = reset_n & ir_write_raw;
   assign RegWrite = reset_n & reg_write_raw;
   assign MemWrite = reset_n & mem_write_raw;
   assign MemReq   = reset_n & mem_req_raw;
   assign ImmSrc   = imm_src_of(op);

   alu_decoder u_alu_decoder (
      .ALUOp      (alu_op),
      .funct3     (funct3),
      .op5        (op[5]),
      .funct7b5   (funct7b5),
      .ALUControl (ALUControl)
   );

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - self-checking bench for multicycle_controller
module tb_multicycle_controller;

`ifdef MEM_HANDSHAKE_EN
   localparam bit HS = 1'b1;
`else
   localparam bit HS = 1'b0;
`endif

   localparam logic [6:0] C_LW  = 7'b0000011;
   localparam logic [6:0] C_SW  = 7'b0100011;
   localparam logic [6:0] C_R   = 7'b0110011;
   localparam logic [6:0] C_I   = 7'b0010011;
   localparam logic [6:0] C_JAL = 7'b1101111;
   localparam logic [6:0] C_BEQ = 7'b1100011;
   localparam logic [6:0] C_LUI = 7'b0110111;
   localparam logic [6:0] C_BAD = 7'b1111111;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [6:0] op;
   logic [2:0] funct3;
   logic       funct7b5, Zero, MemReady;
   logic       PCWrite, AdrSrc, MemWrite, MemReq, IRWrite, RegWrite;
   logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
   logic [2:0] ALUControl, ImmSrc;

   int n_checks = 0;
   int n_fail   = 0;
   int step     = 0;

   logic       snap_pcw [0:7];
   logic       snap_irw [0:7];
   logic       snap_rw  [0:7];
   logic       snap_mw  [0:7];
   logic [1:0] snap_rs  [0:7];
   logic [1:0] snap_sb  [0:7];
   logic [2:0] snap_alu [0:7];
   logic [2:0] snap_imm [0:7];

   multicycle_controller dut (
      .clk(clk), .reset_n(reset_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
      .Zero(Zero), .MemReady(MemReady), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
      .MemWrite(MemWrite), .MemReq(MemReq), .IRWrite(IRWrite), .RegWrite(RegWrite),
      .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
      .ALUControl(ALUControl), .ImmSrc(ImmSrc)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   function automatic int cpi(input logic [6:0] o);
      case (o)
         C_LW:                  cpi = 5;
         C_SW, C_R, C_I, C_JAL: cpi = 4;
         C_BEQ, C_LUI:          cpi = 3;
         default:               cpi = 2;
      endcase
   endfunction

   // Expected outputs from the instruction class and the cycle index inside it.
   function automatic logic [17:0] model(input logic rst_n_i, input logic [6:0] o,
                                         input logic [2:0] f3, input logic f7,
                                         input logic z, input logic rdy, input int st);
      logic pcw, adr, mw, mr, irw, rw;
      logic [1:0] rs, sa, sb;
      logic [2:0] alu, falu, imm;
      {pcw, adr, mw, mr, irw, rw} = 6'b0;
      rs = 2'b00; sa = 2'b00; sb = 2'b00; alu = 3'b000;
      if      (o == C_SW)  imm = 3'b001;
      else if (o == C_BEQ) imm = 3'b010;
      else if (o == C_JAL) imm = 3'b011;
      else if (o == C_LUI) imm = 3'b100;
      else                 imm = 3'b000;
      if      (f3 == 3'b000) falu = (o[5] && f7) ? 3'b001 : 3'b000;
      else if (f3 == 3'b010) falu = 3'b101;
      else if (f3 == 3'b110) falu = 3'b011;
      else if (f3 == 3'b111) falu = 3'b010;
      else                   falu = 3'b000;
      if (!rst_n_i || st == 0) begin
         sb = 2'b10; rs = 2'b10;
         if (rst_n_i) begin
            mr  = 1'b1;
            irw = HS ? rdy : 1'b1;
            pcw = irw;
         end
      end else if (st == 1) begin
         sa = 2'b01; sb = 2'b01;
      end else begin
         case (o)
            C_LW: begin
               if (st == 2) begin sa = 2'b10; sb = 2'b01; end
               if (st == 3) begin adr = 1'b1; mr = 1'b1; end
               if (st == 4) begin rs = 2'b01; rw = 1'b1; end
            end
            C_SW: begin
               if (st == 2) begin sa = 2'b10; sb = 2'b01; end
               if (st == 3) begin adr = 1'b1; mr = 1'b1; mw = 1'b1; end
            end
            C_R: begin
               if (st == 2) begin sa = 2'b10; sb = 2'b00; alu = falu; end
               if (st == 3) rw = 1'b1;
            end
            C_I: begin
               if (st == 2) begin sa = 2'b10; sb = 2'b01; alu = falu; end
               if (st == 3) rw = 1'b1;
            end
            C_JAL: begin
               if (st == 2) begin sa = 2'b01; sb = 2'b10; pcw = 1'b1; end
               if (st == 3) rw = 1'b1;
            end
            C_BEQ: begin sa = 2'b10; sb = 2'b00; alu = 3'b001; pcw = z; end
            C_LUI: begin rs = 2'b11; rw = 1'b1; end
            default: ;
         endcase
      end
      model = {pcw, adr, mw, mr, irw, rw, rs, sa, sb, alu, imm};
   endfunction

   function automatic bit is_mem_wait_step(input logic [6:0] o, input int st);
      is_mem_wait_step = (st == 0) || (st == 3 && (o == C_LW || o == C_SW));
   endfunction

   always @(posedge clk) begin
      if (!reset_n)                                          step <= 0;
      else if (HS && !MemReady && is_mem_wait_step(op, step)) step <= step;
      else if (step + 1 >= cpi(op))                          step <= 0;
      else                                                   step <= step + 1;
   end

   always @(negedge clk) begin
      check("cycle_outputs",
            {14'b0, PCWrite, AdrSrc, MemWrite, MemReq, IRWrite, RegWrite,
             ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc},
            {14'b0, model(reset_n, op, funct3, funct7b5, Zero, MemReady, step)});
   end

   task automatic cyc(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                      input logic z, input logic rdy, input logic rst_n_i);
      @(posedge clk);
      #1;
      op = o; funct3 = f3; funct7b5 = f7; Zero = z; MemReady = rdy; reset_n = rst_n_i;
      @(negedge clk);
   endtask

   task automatic instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                        input logic z);
      for (int s = 0; s < cpi(o); s++) begin
         cyc(o, f3, f7, z, HS ? 1'b1 : logic'(s % 2), 1'b1);
         snap_pcw[s] = PCWrite;  snap_irw[s] = IRWrite;  snap_rw[s]  = RegWrite;
         snap_mw[s]  = MemWrite; snap_rs[s]  = ResultSrc; snap_sb[s] = ALUSrcB;
         snap_alu[s] = ALUControl; snap_imm[s] = ImmSrc;
      end
   endtask

   initial begin
      reset_n = 1'b0; op = C_R; funct3 = 3'b000; funct7b5 = 1'b0; Zero = 1'b0; MemReady = 1'b1;

      for (int i = 0; i < 3; i++) begin
         cyc(C_R, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0);
         check("reset_wen", {PCWrite, IRWrite, RegWrite, MemWrite, MemReq}, 5'b00000);
      end
      instr(C_R, 3'b000, 1'b0, 1'b0);
      check("release_irwrite", snap_irw[0], 1'b1);
      check("release_pcwrite", snap_pcw[0], 1'b1);
      check("release_alusrcb", snap_sb[0], 2'b10);
      check("release_resultsrc", snap_rs[0], 2'b10);

      instr(C_LW, 3'b010, 1'b0, 1'b0);
      check("lw_memwb_resultsrc", snap_rs[4], 2'b01);
      check("lw_memwb_regwrite", snap_rw[4], 1'b1);

      instr(C_BEQ, 3'b000, 1'b0, 1'b1);
      check("beq_taken_pcwrite", snap_pcw[2], 1'b1);
      check("beq_alucontrol", snap_alu[2], 3'b001);
      instr(C_BEQ, 3'b000, 1'b0, 1'b0);
      check("beq_not_taken_pcwrite", snap_pcw[2], 1'b0);

      instr(C_LUI, 3'b000, 1'b0, 1'b0);
      check("lui_resultsrc", snap_rs[2], 2'b11);
      check("lui_regwrite", snap_rw[2], 1'b1);
      check("lui_immsrc", snap_imm[2], 3'b100);

      instr(C_BAD, 3'b000, 1'b0, 1'b0);
      check("after_lui_fetch", snap_irw[0], 1'b1);
      check("bad_no_regwrite", snap_rw[1], 1'b0);
      check("bad_no_memwrite", snap_mw[1], 1'b0);

      instr(C_R, 3'b000, 1'b1, 1'b0);
      check("after_bad_fetch", snap_irw[0], 1'b1);
      check("sub_alucontrol", snap_alu[2], 3'b001);

      instr(C_SW, 3'b010, 1'b0, 1'b0);
      check("sw_memwrite", snap_mw[3], 1'b1);
      instr(C_I, 3'b000, 1'b1, 1'b0);
      check("addi_f7_alucontrol", snap_alu[2], 3'b000);
      instr(C_I, 3'b010, 1'b0, 1'b0);
      instr(C_I, 3'b110, 1'b0, 1'b0);
      instr(C_I, 3'b111, 1'b0, 1'b0);
      instr(C_R, 3'b111, 1'b0, 1'b0);
      check("and_alucontrol", snap_alu[2], 3'b010);
      instr(C_R, 3'b010, 1'b0, 1'b0);
      instr(C_R, 3'b001, 1'b1, 1'b0);
      instr(C_JAL, 3'b000, 1'b0, 1'b0);
      check("jal_pcwrite", snap_pcw[2], 1'b1);
      instr(C_BEQ, 3'b000, 1'b0, 1'b1);

      // reset during a load: abandon it, no late register write
      for (int i = 0; i < 3; i++) cyc(C_LW, 3'b010, 1'b0, 1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 2; i++) begin
         cyc(C_LW, 3'b010, 1'b0, 1'b0, 1'b1, 1'b0);
         check("midreset_wen", {RegWrite, MemReq, IRWrite}, 3'b000);
      end
      instr(C_LW, 3'b010, 1'b0, 1'b0);
      check("midreset_release_fetch", snap_irw[0], 1'b1);
      instr(C_LUI, 3'b000, 1'b0, 1'b0);

`ifdef MEM_HANDSHAKE_EN
      cyc(C_SW, 3'b010, 1'b0, 1'b0, 1'b1, 1'b1);
      cyc(C_SW, 3'b010, 1'b0, 1'b0, 1'b1, 1'b1);
      cyc(C_SW, 3'b010, 1'b0, 1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) begin
         cyc(C_SW, 3'b010, 1'b0, 1'b0, (i == 2), 1'b1);
         check("hs_memwrite_held", {MemWrite, MemReq}, 2'b11);
      end
      for (int i = 0; i < 2; i++) begin
         cyc(C_SW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1);
         check("hs_fetch_wait", {IRWrite, PCWrite, MemReq}, 3'b001);
      end
      cyc(C_SW, 3'b010, 1'b0, 1'b0, 1'b1, 1'b1);
      check("hs_fetch_ready", {IRWrite, PCWrite}, 2'b11);
      for (int i = 0; i < 3; i++) cyc(C_SW, 3'b010, 1'b0, 1'b0, 1'b1, 1'b1);
      instr(C_LW, 3'b000, 1'b0, 1'b0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Main control unit for the multicycle RISC-V datapath. Sequences each instruction through fetch, decode, execute, memory and writeback states. Drives every datapath select and write enable, including the 2-bit `ResultSrc` of the result mux (00 ALUOut, 01 Data, 10 ALUResult, 11 ImmExt). Optionally stalls on a memory ready handshake.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `op`  in  7  instruction opcode, bits [6:0] of the IR.
- `funct3`  in  3  instruction bits [14:12].
- `funct7b5`  in  1  instruction bit 30.
- `Zero`  in  1  ALU zero flag.
- `MemReady`  in  1  memory completion strobe; ignored unless `MEM_HANDSHAKE_EN` is defined.
- `PCWrite`  out  1  PC register enable; equals `PCUpdate | (Branch & Zero)`.
- `AdrSrc`  out  1  memory address select: 0 = PC, 1 = Result.
- `MemWrite`  out  1  data memory write enable.
- `MemReq`  out  1  memory access request.
- `IRWrite`  out  1  instruction and OldPC register enable.
- `RegWrite`  out  1  register file write enable.
- `ResultSrc`  out  2  result mux select (encodings above).
- `ALUSrcA`  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = A register.
- `ALUSrcB`  out  2  ALU B select: 00 = WriteData register, 01 = ImmExt, 10 = constant 4.
- `ALUControl`  out  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 101 slt.
- `ImmSrc`  out  3  immediate format: 000 I, 001 S, 010 B, 011 J, 100 U.

## Operation
- State register is `state_t`. Reset value is FETCH. Next-state logic and outputs are combinational from state and the inputs (Moore outputs, except `PCWrite` and handshake gating).
- Any output not listed for a state is 0.
- FETCH: AdrSrc=0, MemReq=1, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=1. Next: DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (computes the branch target). Next state by `op`:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECUTER
  - 0010011 -> EXECUTEI
  - 1101111 -> JAL
  - 1100011 -> BEQ
  - 0110111 -> LUI
  - any other opcode -> FETCH, with no writes.
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Next: MEMREAD if op=0000011, else MEMWRITE.
- MEMREAD: AdrSrc=1, ResultSrc=00, MemReq=1. Next: MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1. Next: FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemReq=1, MemWrite=1. Next: FETCH.
- EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Next: ALUWB.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Next: ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1. Next: FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1. Next: ALUWB.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1. Next: FETCH.
- LUI: ResultSrc=11, RegWrite=1. Next: FETCH.
- ALU decode:
  - ALUOp=00 -> add.
  - ALUOp=01 -> sub.
  - ALUOp=10 -> decode by `funct3`: 000 gives add, or sub when `op[5]&funct7b5`; 010 slt; 110 or; 111 and; any other funct3 -> add.
- ImmSrc is decoded from `op` in every state: lw/I-type -> I; sw -> S; beq -> B; jal -> J; lui -> U; unknown -> I.

## Timing
- Cycles per instruction, with no stalls:
  - lw 5
  - sw 4
  - R-type 4
  - I-type 4
  - jal 4
  - beq 3
  - lui 3
  - unknown opcode 2
- `Zero` is sampled combinationally in BEQ. PCWrite is high in that same cycle iff Zero=1.
- Reset:
  - While reset_n=0, PCWrite, IRWrite, RegWrite, MemWrite and MemReq are forced to 0. Selects take their FETCH values.
  - An assertion mid-instruction abandons the instruction immediately. There is no partial write after release.
- After reset_n deasserts, the first rising edge acts as a FETCH cycle.

## Configuration
- `MEM_HANDSHAKE_EN` defined:
  - FETCH, MEMREAD and MEMWRITE hold their state until MemReady=1 is sampled on a rising edge.
  - In FETCH, IRWrite and PCUpdate are asserted only in the cycle where MemReady=1.
  - In MEMWRITE, MemWrite and MemReq stay high throughout the wait.
  - Each wait cycle adds one cycle to the instruction.
- `MEM_HANDSHAKE_EN` undefined: MemReady is ignored, every memory state lasts one cycle, and MemReq is still driven as listed.

## Structure
- `controller_pkg` holds:
  - `state_t` enum (12 states);
  - opcode localparams (OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BEQ, OP_LUI);
  - ResultSrc, ALUSrcA, ALUSrcB, ImmSrc and ALUControl encoding constants;
  - the `aluop_t` 2-bit type.
- One sub-module, `alu_decoder` (inputs ALUOp, funct3, op[5], funct7b5; output ALUControl). It is instantiated once. The FSM and the PCWrite/handshake gating stay in the top module.

## Test plan
- Reset held 3 cycles with op=0110011 -> all write enables 0; release -> FETCH with IRWrite=1, PCWrite=1, ALUSrcB=10, ResultSrc=10.
- lw (op=0000011) -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB over 5 cycles; MEMWB shows ResultSrc=01, RegWrite=1.
- beq (op=1100011) with Zero=1 -> PCWrite=1 in the third cycle, ALUControl=001; repeat with Zero=0 -> PCWrite=0.
- lui (op=0110111) -> third cycle ResultSrc=11, RegWrite=1, ImmSrc=100; next cycle is FETCH.
- sub (op=0110011, funct3=000, funct7b5=1) -> EXECUTER shows ALUControl=001; unknown op 1111111 -> returns to FETCH after DECODE with no RegWrite or MemWrite.
- With MEM_HANDSHAKE_EN, sw with MemReady low for 2 cycles -> MEMWRITE lasts 3 cycles with MemWrite=1 throughout; FETCH with MemReady low -> IRWrite=0 and PCWrite=0 until MemReady=1.
